nios_timer_driver: RTL and testbench
====================================

Name: nios_timer_driver

Overview:
- Avalon-MM initiator that owns and services the 16-bit-data interval timer slave.
- Programs a 32-bit period, starts the timer in continuous mode with IRQ enabled, and acknowledges each timeout.
- Keeps a 32-bit tick count and performs on-demand snapshot reads of the live counter.
- Sits between fabric-side control logic and the timer's s1 port. It replaces software servicing of the timer's status register.

Parameters:
- DEFAULT_PERIOD, 32'd49999: period used when cfg_period is 0 at cfg_start.
- CTRL_RUN, 16'h0007: control word written to start the timer (START | CONT | ITO).
- CTRL_HALT, 16'h0008: control word written on stop (STOP, IRQ disabled).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: program period and start; honoured only in IDLE
- cfg_period  in  32  timer period, sampled on accepted cfg_start
- cfg_stop  in  1  pulse: halt timer; latched as pending
- snap_req  in  1  pulse: capture counter snapshot; latched as pending
- timer_irq  in  1  timer interrupt, level
- av_address  out  3  timer register index
- av_chipselect  out  1  bus select
- av_write_n  out  1  write strobe, active-low
- av_writedata  out  16  write data
- av_readdata  in  16  timer read data, registered by slave, fixed latency 1
- busy  out  1  high in any state other than IDLE or RUN
- running  out  1  high in RUN and its service states
- tick_count  out  32  acknowledged timeouts since last cfg_start
- snap_value  out  32  last snapshot {high, low}
- snap_valid  out  1  one-cycle pulse when snap_value updates

Behaviour:
- Reset values:
  - av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
  - busy=0, running=0, tick_count=0, snap_value=0, snap_valid=0.
  - Pending flags cleared; FSM goes to IDLE.
  - Reset mid-transaction abandons the access. The bus is idle the cycle after reset.
- Bus idle value: chipselect=0, write_n=1, address/writedata hold 0.
- Bus access rules:
  - Every access is a single cycle with chipselect=1. The slave has no waitrequest.
  - Write: write_n=0.
  - Read: write_n=1. Data is sampled at the clock edge ending the cycle after the address cycle.
- FSM, one state per bus cycle:
  - IDLE: on cfg_start, latch period (DEFAULT_PERIOD if cfg_period==0), clear tick_count, go to WR_PL.
  - WR_PL: write addr 2 with period[15:0]; go to WR_PH.
  - WR_PH: write addr 3 with period[31:16]; go to WR_CTRL.
  - WR_CTRL: write addr 1 with CTRL_RUN; go to RUN. The timer's start strobe overrides its period-write reload stop.
  - RUN: evaluate in priority order: stop pending > timer_irq > snap pending. Otherwise stay, with the bus idle.
  - HALT: write addr 1 with CTRL_HALT, clear stop pending, go to IDLE. Any pending snapshot is discarded.
  - ACK: write addr 0 with 0, tick_count += 1 (wraps 32'hFFFFFFFF -> 0), go to RUN. timer_irq is low by the next cycle, so no double count.
  - SN_WR: write addr 4 (data 0), which triggers the slave's snapshot; go to SN_RL.
  - SN_RL: read addr 4; go to SN_RH.
  - SN_RH: read addr 5; capture av_readdata as low half; go to SN_CAP.
  - SN_CAP: bus idle; capture av_readdata as high half, pulse snap_valid, clear snap pending, go to RUN.
- Pending flags:
  - cfg_stop and snap_req set flags in any state.
  - A flag raised during its own service sequence stays set and is served again.
  - Both flags are ignored and cleared in IDLE.
- Start requests: cfg_start outside IDLE is dropped. cfg_start and cfg_stop asserted in the same IDLE cycle: start wins, and the stop is discarded.
- Latency:
  - cfg_start to first period write: 1 cycle. Start sequence: 3 bus cycles.
  - irq seen in RUN to status clear: 1 cycle.
  - snap_req in RUN to snap_valid: 5 cycles.
- running is high in RUN, ACK and SN_*. busy = !(IDLE || RUN).
- timer_irq in IDLE is ignored.

Decomposition:
- Package nios_timer_pkg holds:
  - register index constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5);
  - control bit positions (ITO=0, CONT=1, START=2, STOP=3);
  - the FSM state enum.
- One sub-module, nios_timer_bus_if: registers the bus outputs from a one-cycle command (rd/wr, addr, data) and supplies the read-capture strobe.

Test Plan:
- Reset, then cfg_start with cfg_period=32'h0001_86A0 -> writes (2,16'h86A0), (3,16'h0001), (1,16'h0007) on consecutive cycles; running=1, busy=0 on cycle 4.
- cfg_start with cfg_period=0 -> period writes 16'hC34F then 16'h0000.
- Timer model with period 9 runs 3 timeouts -> exactly 3 writes of 0 to addr 0; tick_count=3; irq drops after each ACK.
- snap_req while the model counter=32'h0002_1234 -> writes addr 4, reads 4 then 5; snap_value=32'h0002_1234; snap_valid high for exactly one cycle, 5 cycles after the request.
- snap_req, timer_irq and cfg_stop asserted in the same RUN cycle -> HALT write (1,16'h0008), then IDLE; no ACK, no snap_valid; tick_count unchanged.
- reset asserted during SN_RL -> next cycle chipselect=0, snap_valid=0, FSM in IDLE; tick_count forced to 0.

Source files
------------

// File: rtl/nios_timer_pkg.sv
// ============================================================================
//  Module      : nios_timer_pkg
//  Description : Shared definitions for the interval-timer driver: timer
//                register map, control-word bit positions, driver FSM states
//                and the one-cycle bus command carried to the bus interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nios_timer_pkg;

   // Timer s1 register indices
   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_CONTROL = 3'd1;
   localparam logic [2:0] REG_PERIODL = 3'd2;
   localparam logic [2:0] REG_PERIODH = 3'd3;
   localparam logic [2:0] REG_SNAPL   = 3'd4;
   localparam logic [2:0] REG_SNAPH   = 3'd5;

   // Control register bit positions
   localparam int CTRL_BIT_ITO   = 0;
   localparam int CTRL_BIT_CONT  = 1;
   localparam int CTRL_BIT_START = 2;
   localparam int CTRL_BIT_STOP  = 3;

   // Driver FSM: one state per bus cycle
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_WR_PL   = 4'd1,
      ST_WR_PH   = 4'd2,
      ST_WR_CTRL = 4'd3,
      ST_RUN     = 4'd4,
      ST_HALT    = 4'd5,
      ST_ACK     = 4'd6,
      ST_SN_WR   = 4'd7,
      ST_SN_RL   = 4'd8,
      ST_SN_RH   = 4'd9,
      ST_SN_CAP  = 4'd10
   } state_e;

   // Single-cycle access request handed to the bus interface
   typedef struct packed {
      logic        valid;
      logic        wr;
      logic [2:0]  addr;
      logic [15:0] data;
   } bus_cmd_t;

   // States in which the timer is considered to be running
   function automatic logic state_is_running(state_e s);
      return (s == ST_RUN) || (s == ST_ACK) || (s == ST_SN_WR) ||
             (s == ST_SN_RL) || (s == ST_SN_RH) || (s == ST_SN_CAP);
   endfunction

   // States in which the driver is occupied with a bus sequence
   function automatic logic state_is_busy(state_e s);
      return (s != ST_IDLE) && (s != ST_RUN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nios_timer_bus_if.sv
// ============================================================================
//  Module      : nios_timer_bus_if
//  Description : Registers the Avalon-MM initiator outputs from a one-cycle
//                command and raises rd_capture in the cycle where the slave's
//                fixed-latency read data is present on av_readdata.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_timer_bus_if
   import nios_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  bus_cmd_t    cmd,
   output logic [2:0]  av_address,
   output logic        av_chipselect,
   output logic        av_write_n,
   output logic [15:0] av_writedata,
   output logic        rd_capture
);

   logic [2:0]  av_address_q,    av_address_d;
   logic        av_chipselect_q, av_chipselect_d;
   logic        av_write_n_q,    av_write_n_d;
   logic [15:0] av_writedata_q,  av_writedata_d;
   logic        rd_capture_q,    rd_capture_d;

   // Translate the command into bus levels; no command means idle bus with zeros
   always_comb begin
      av_address_d    = 3'd0;
      av_chipselect_d = 1'b0;
      av_write_n_d    = 1'b1;
      av_writedata_d  = 16'h0000;
      // The slave registers read data, so it is valid the cycle after a read
      rd_capture_d    = av_chipselect_q & av_write_n_q;
      if (cmd.valid) begin
         av_address_d    = cmd.addr;
         av_chipselect_d = 1'b1;
         av_write_n_d    = ~cmd.wr;
         av_writedata_d  = cmd.wr ? cmd.data : 16'h0000;
      end
   end

   // Bus output registers; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         av_address_q    <= 3'd0;
         av_chipselect_q <= 1'b0;
         av_write_n_q    <= 1'b1;
         av_writedata_q  <= 16'h0000;
         rd_capture_q    <= 1'b0;
      end else begin
         av_address_q    <= av_address_d;
         av_chipselect_q <= av_chipselect_d;
         av_write_n_q    <= av_write_n_d;
         av_writedata_q  <= av_writedata_d;
         rd_capture_q    <= rd_capture_d;
      end
   end

   assign av_address    = av_address_q;
   assign av_chipselect = av_chipselect_q;
   assign av_write_n    = av_write_n_q;
   assign av_writedata  = av_writedata_q;
   assign rd_capture    = rd_capture_q;

endmodule

`default_nettype wire

// File: rtl/nios_timer_driver.sv
// ============================================================================
//  Module      : nios_timer_driver
//  Description : Avalon-MM initiator servicing a 16-bit interval timer:
//                programs the period, starts continuous IRQ mode, acknowledges
//                timeouts, counts ticks and performs counter snapshot reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_timer_driver
   import nios_timer_pkg::*;
#(
   parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
   parameter logic [15:0] CTRL_RUN       = 16'h0007,
   parameter logic [15:0] CTRL_HALT      = 16'h0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_start,
   input  logic [31:0] cfg_period,
   input  logic        cfg_stop,
   input  logic        snap_req,
   input  logic        timer_irq,
   output logic [2:0]  av_address,
   output logic        av_chipselect,
   output logic        av_write_n,
   output logic [15:0] av_writedata,
   input  logic [15:0] av_readdata,
   output logic        busy,
   output logic        running,
   output logic [31:0] tick_count,
   output logic [31:0] snap_value,
   output logic        snap_valid
);

   state_e      state_q,      state_d;
   logic [31:0] period_q,     period_d;
   logic [31:0] tick_count_q, tick_count_d;
   logic        stop_pend_q,  stop_pend_d;
   logic        snap_pend_q,  snap_pend_d;
   logic [15:0] snap_lo_q,    snap_lo_d;
   logic [31:0] snap_value_q, snap_value_d;
   logic        snap_valid_q, snap_valid_d;
   logic        running_q,    running_d;
   logic        busy_q,       busy_d;

   bus_cmd_t    bus_cmd;
   logic        rd_capture;

   // A request arriving this cycle is acted on immediately in RUN
   logic        stop_now;
   logic        snap_now;
   assign stop_now = stop_pend_q | cfg_stop;
   assign snap_now = snap_pend_q | snap_req;

   // Next-state, pending-flag and datapath logic
   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      tick_count_d = tick_count_q;
      stop_pend_d  = stop_now;
      snap_pend_d  = snap_now;
      snap_lo_d    = snap_lo_q;
      snap_value_d = snap_value_q;
      snap_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Requests have no meaning while stopped; a start also swallows a
            // simultaneous stop
            stop_pend_d = 1'b0;
            snap_pend_d = 1'b0;
            if (cfg_start) begin
               period_d     = (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
               tick_count_d = 32'd0;
               state_d      = ST_WR_PL;
            end
         end
         ST_WR_PL:   state_d = ST_WR_PH;
         ST_WR_PH:   state_d = ST_WR_CTRL;
         ST_WR_CTRL: state_d = ST_RUN;
         ST_RUN: begin
            if (stop_now) begin
               state_d = ST_HALT;
            end else if (timer_irq) begin
               state_d = ST_ACK;
            end else if (snap_now) begin
               // Flag drops when service begins so that a request raised
               // during SN_* re-arms it and earns its own snapshot
               snap_pend_d = 1'b0;
               state_d     = ST_SN_WR;
            end
         end
         ST_HALT: begin
            stop_pend_d = 1'b0;
            snap_pend_d = 1'b0;
            state_d     = ST_IDLE;
         end
         ST_ACK: begin
            tick_count_d = tick_count_q + 32'd1;
            state_d      = ST_RUN;
         end
         ST_SN_WR: state_d = ST_SN_RL;
         ST_SN_RL: state_d = ST_SN_RH;
         ST_SN_RH: begin
            if (rd_capture) begin
               snap_lo_d = av_readdata;
            end
            state_d = ST_SN_CAP;
         end
         ST_SN_CAP: begin
            if (rd_capture) begin
               snap_value_d = {av_readdata, snap_lo_q};
               snap_valid_d = 1'b1;
            end
            state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase

      running_d = state_is_running(state_d);
      busy_d    = state_is_busy(state_d);
   end

   // Bus command for the state being entered, so it is on the bus during it
   always_comb begin
      bus_cmd = '0;
      case (state_d)
         ST_WR_PL: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.wr    = 1'b1;
            bus_cmd.addr  = REG_PERIODL;
            bus_cmd.data  = period_d[15:0];
         end
         ST_WR_PH: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.wr    = 1'b1;
            bus_cmd.addr  = REG_PERIODH;
            bus_cmd.data  = period_d[31:16];
         end
         ST_WR_CTRL: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.wr    = 1'b1;
            bus_cmd.addr  = REG_CONTROL;
            bus_cmd.data  = CTRL_RUN;
         end
         ST_HALT: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.wr    = 1'b1;
            bus_cmd.addr  = REG_CONTROL;
            bus_cmd.data  = CTRL_HALT;
         end
         ST_ACK: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.wr    = 1'b1;
            bus_cmd.addr  = REG_STATUS;
            bus_cmd.data  = 16'h0000;
         end
         ST_SN_WR: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.wr    = 1'b1;
            bus_cmd.addr  = REG_SNAPL;
            bus_cmd.data  = 16'h0000;
         end
         ST_SN_RL: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.addr  = REG_SNAPL;
         end
         ST_SN_RH: begin
            bus_cmd.valid = 1'b1;
            bus_cmd.addr  = REG_SNAPH;
         end
         default: bus_cmd = '0;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         period_q     <= 32'd0;
         tick_count_q <= 32'd0;
         stop_pend_q  <= 1'b0;
         snap_pend_q  <= 1'b0;
         snap_lo_q    <= 16'h0000;
         snap_value_q <= 32'd0;
         snap_valid_q <= 1'b0;
         running_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         tick_count_q <= tick_count_d;
         stop_pend_q  <= stop_pend_d;
         snap_pend_q  <= snap_pend_d;
         snap_lo_q    <= snap_lo_d;
         snap_value_q <= snap_value_d;
         snap_valid_q <= snap_valid_d;
         running_q    <= running_d;
         busy_q       <= busy_d;
      end
   end

   nios_timer_bus_if u_bus_if (
      .clk           (clk),
      .reset         (reset),
      .cmd           (bus_cmd),
      .av_address    (av_address),
      .av_chipselect (av_chipselect),
      .av_write_n    (av_write_n),
      .av_writedata  (av_writedata),
      .rd_capture    (rd_capture)
   );

   assign busy       = busy_q;
   assign running    = running_q;
   assign tick_count = tick_count_q;
   assign snap_value = snap_value_q;
   assign snap_valid = snap_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_timer_driver.sv
// ============================================================================
//  Module      : tb_nios_timer_driver
//  Description : Bench for nios_timer_driver with a behavioural interval
//                timer slave, expected-access and expected-snapshot queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nios_timer_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_start = 1'b0;
   logic [31:0] cfg_period = 32'd0;
   logic        cfg_stop = 1'b0;
   logic        snap_req = 1'b0;
   logic        timer_irq;
   logic [2:0]  av_address;
   logic        av_chipselect;
   logic        av_write_n;
   logic [15:0] av_writedata;
   logic [15:0] av_readdata;
   logic        busy;
   logic        running;
   logic [31:0] tick_count;
   logic [31:0] snap_value;
   logic        snap_valid;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [15:0] data;
      int          at;
   } bus_exp_t;

   typedef struct {
      logic [31:0] value;
      int          at;
   } snap_exp_t;

   bus_exp_t  bus_q[$];
   snap_exp_t snap_q[$];

   nios_timer_driver dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_start     (cfg_start),
      .cfg_period    (cfg_period),
      .cfg_stop      (cfg_stop),
      .snap_req      (snap_req),
      .timer_irq     (timer_irq),
      .av_address    (av_address),
      .av_chipselect (av_chipselect),
      .av_write_n    (av_write_n),
      .av_writedata  (av_writedata),
      .av_readdata   (av_readdata),
      .busy          (busy),
      .running       (running),
      .tick_count    (tick_count),
      .snap_value    (snap_value),
      .snap_valid    (snap_valid)
   );

   // ---------------- behavioural interval timer slave ----------------
   logic [31:0] m_period = 32'd0;
   logic [31:0] m_count = 32'd0;
   logic [31:0] m_snap = 32'd0;
   logic        m_run = 1'b0;
   logic        m_ito = 1'b0;
   logic        m_to = 1'b0;
   logic [15:0] m_rdata = 16'h0000;
   logic        m_count_en = 1'b1;
   logic        model_en = 1'b1;
   logic        irq_drv = 1'b0;
   int          timeouts = 0;

   assign av_readdata = m_rdata;
   assign timer_irq   = model_en ? (m_to & m_ito) : irq_drv;

   always @(posedge clk) begin
      m_rdata <= 16'h0000;
      if (av_chipselect === 1'b1 && av_write_n === 1'b1) begin
         if (av_address == 3'd4) m_rdata <= m_snap[15:0];
         else if (av_address == 3'd5) m_rdata <= m_snap[31:16];
      end
      if (m_run && m_count_en) begin
         if (m_count == 32'd0) begin
            m_count <= m_period;
            m_to    <= 1'b1;
            if (m_ito && model_en) begin
               // The driver owes exactly one status clear for this timeout
               bus_q.push_back('{wr: 1'b1, addr: 3'd0, data: 16'h0000, at: -1});
               timeouts <= timeouts + 1;
            end
         end else begin
            m_count <= m_count - 32'd1;
         end
      end
      if (av_chipselect === 1'b1 && av_write_n === 1'b0) begin
         case (av_address)
            3'd0: m_to <= 1'b0;
            3'd1: begin
               m_ito <= av_writedata[0];
               if (av_writedata[3]) m_run <= 1'b0;
               else if (av_writedata[2]) m_run <= 1'b1;
            end
            3'd2: begin
               m_period[15:0] <= av_writedata;
               m_count        <= {m_period[31:16], av_writedata};
               m_run          <= 1'b0;
            end
            3'd3: begin
               m_period[31:16] <= av_writedata;
               m_count         <= {av_writedata, m_period[15:0]};
               m_run           <= 1'b0;
            end
            3'd4: m_snap <= m_count;
            default: ;
         endcase
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_bus(input logic wr, input logic [2:0] a, input logic [15:0] d, input int at);
      bus_q.push_back('{wr: wr, addr: a, data: d, at: at});
   endtask

   // ---------------- bus monitor ----------------
   logic ack_prev = 1'b0;
   always @(negedge clk) begin
      bus_exp_t e;
      if (ack_prev) chk("irq_low_after_ack", {31'd0, timer_irq}, 32'd0);
      ack_prev = 1'b0;
      if (av_chipselect === 1'b1) begin
         checks++;
         if (bus_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=%h at cycle %0d, required no access",
                     !av_write_n, av_address, av_writedata, cyc);
         end else begin
            e = bus_q.pop_front();
            if (((!av_write_n) !== e.wr) || (av_address !== e.addr) ||
                (e.wr && (av_writedata !== e.data)) || ((e.at >= 0) && (cyc != e.at))) begin
               errors++;
               $display("FAIL bus_access: got wr=%0b addr=%0d data=%h cycle=%0d, required wr=%0b addr=%0d data=%h cycle=%0d",
                        !av_write_n, av_address, av_writedata, cyc, e.wr, e.addr, e.data, e.at);
            end
            if (e.wr && e.addr == 3'd0) ack_prev = 1'b1;
         end
      end
   end

   // ---------------- snapshot monitor ----------------
   always @(negedge clk) begin
      snap_exp_t s;
      if (snap_valid === 1'b1) begin
         checks++;
         if (snap_q.size() == 0) begin
            errors++;
            $display("FAIL snap_unexpected: got snap_valid with value %h at cycle %0d, required none",
                     snap_value, cyc);
         end else begin
            s = snap_q.pop_front();
            if ((snap_value !== s.value) || (cyc != s.at)) begin
               errors++;
               $display("FAIL snap: got value %h cycle %0d, required value %h cycle %0d",
                        snap_value, cyc, s.value, s.at);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_cycle(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   task automatic do_start(input logic [31:0] per, input logic [31:0] exp_per);
      int c0;
      step(1);
      c0 = cyc;
      cfg_period = per;
      cfg_start  = 1'b1;
      exp_bus(1'b1, 3'd2, exp_per[15:0], c0 + 1);
      exp_bus(1'b1, 3'd3, exp_per[31:16], c0 + 2);
      exp_bus(1'b1, 3'd1, 16'h0007, c0 + 3);
      step(1);
      cfg_start = 1'b0;
      at_cycle(c0 + 2);
      chk("busy_in_start_seq", {31'd0, busy}, 32'd1);
      at_cycle(c0 + 4);
      chk("running_after_start", {31'd0, running}, 32'd1);
      chk("busy_after_start", {31'd0, busy}, 32'd0);
   endtask

   task automatic do_stop();
      int c0;
      step(1);
      c0 = cyc;
      cfg_stop = 1'b1;
      exp_bus(1'b1, 3'd1, 16'h0008, c0 + 1);
      step(1);
      cfg_stop = 1'b0;
      at_cycle(c0 + 3);
      chk("running_after_stop", {31'd0, running}, 32'd0);
      chk("busy_after_stop", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int c0;
      int t0;

      // Reset state
      step(3);
      @(negedge clk);
      chk("rst_chipselect", {31'd0, av_chipselect}, 32'd0);
      chk("rst_write_n", {31'd0, av_write_n}, 32'd1);
      chk("rst_address", {29'd0, av_address}, 32'd0);
      chk("rst_writedata", {16'd0, av_writedata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_tick_count", tick_count, 32'd0);
      chk("rst_snap_value", snap_value, 32'd0);
      chk("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
      step(1);
      reset = 1'b0;

      // Explicit period, then the default period substitution
      do_start(32'h0001_86A0, 32'h0001_86A0);
      chk("tick_after_start", tick_count, 32'd0);
      do_stop();
      do_start(32'd0, 32'h0000_C34F);
      do_stop();

      // Three timeouts at period 9
      t0 = timeouts;
      do_start(32'd9, 32'd9);
      for (int i = 0; i < 300 && timeouts < t0 + 3; i++) step(1);
      if (timeouts < t0 + 3) begin
         checks++;
         errors++;
         $display("FAIL timeout_wait: got %0d timeouts, required 3", timeouts - t0);
      end
      step(3);
      chk("tick_count_3", tick_count, 32'd3);

      // Stop, irq and snapshot in the same RUN cycle: stop has priority
      step(1);
      c0 = cyc;
      model_en = 1'b0;
      irq_drv  = 1'b1;
      snap_req = 1'b1;
      cfg_stop = 1'b1;
      exp_bus(1'b1, 3'd1, 16'h0008, c0 + 1);
      step(1);
      snap_req = 1'b0;
      cfg_stop = 1'b0;
      step(6);
      @(negedge clk);
      chk("prio_running", {31'd0, running}, 32'd0);
      chk("prio_busy", {31'd0, busy}, 32'd0);
      chk("prio_tick_count", tick_count, 32'd3);
      irq_drv  = 1'b0;
      model_en = 1'b1;

      // Snapshot of a frozen counter, plus one re-request during the sequence
      m_count_en = 1'b0;
      do_start(32'h0002_1234, 32'h0002_1234);
      step(1);
      c0 = cyc;
      snap_req = 1'b1;
      exp_bus(1'b1, 3'd4, 16'h0000, c0 + 1);
      exp_bus(1'b0, 3'd4, 16'h0000, c0 + 2);
      exp_bus(1'b0, 3'd5, 16'h0000, c0 + 3);
      snap_q.push_back('{value: 32'h0002_1234, at: c0 + 5});
      step(1);
      snap_req = 1'b0;
      step(1);
      snap_req = 1'b1;
      exp_bus(1'b1, 3'd4, 16'h0000, c0 + 6);
      exp_bus(1'b0, 3'd4, 16'h0000, c0 + 7);
      exp_bus(1'b0, 3'd5, 16'h0000, c0 + 8);
      snap_q.push_back('{value: 32'h0002_1234, at: c0 + 10});
      step(1);
      snap_req = 1'b0;
      at_cycle(c0 + 11);
      chk("snap_value_held", snap_value, 32'h0002_1234);
      chk("snap_running", {31'd0, running}, 32'd1);

      // Reset while the low snapshot half is being read
      step(1);
      c0 = cyc;
      snap_req = 1'b1;
      exp_bus(1'b1, 3'd4, 16'h0000, c0 + 1);
      exp_bus(1'b0, 3'd4, 16'h0000, c0 + 2);
      step(1);
      snap_req = 1'b0;
      step(1);
      reset = 1'b1;
      at_cycle(c0 + 3);
      chk("midrst_chipselect", {31'd0, av_chipselect}, 32'd0);
      chk("midrst_snap_valid", {31'd0, snap_valid}, 32'd0);
      chk("midrst_running", {31'd0, running}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_tick_count", tick_count, 32'd0);
      step(1);
      reset = 1'b0;
      step(6);

      @(negedge clk);
      chk("bus_queue_drained", bus_q.size(), 32'd0);
      chk("snap_queue_drained", snap_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
